fetch_sequencer: RTL and testbench

Owns the fetch PC and the IF/ID register for the MIPS pipeline, and sequences instruction-memory requests. It applies redirects from decode with MIPS delay-slot semantics: the instruction after a branch or jump always executes, and the target is fetched next. Its Fetch_PCPlus4 output feeds Instr_PC_Plus4 of the next-address calculator, and that calculator's NextInstructionAddress returns here as Redirect_Target.

---
 rtl/fetch_sequencer_pkg.sv | 25 ++
 rtl/fetch_skid_buffer.sv | 53 +++++
 rtl/fetch_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// fetch_sequencer_pkg
// Shared definitions for the MIPS fetch sequencer: reset vector, instruction
// size, sequencer state encoding and the IF/ID payload layout.
// No ports (package).
// ----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] INSTR_BYTES  = 32'd4;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        IDLE   = 2'd2,
        HALTED = 2'd3
    } fetchState_e;

    // One fetched instruction together with the address after it.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcPlus4;
    } ifidEntry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// ----------------------------------------------------------------------------
// fetch_skid_buffer
// One-entry holding register for an instruction that arrived from memory while
// IF/ID was stalled with a valid instruction.
// Ports:
//   CLK, RESET_N  clock, asynchronous active-low reset
//   clear         empty the buffer (highest priority)
//   load          capture loadEntry and mark full
//   drain         mark empty (entry consumed by IF/ID)
//   loadEntry     {instr, pcPlus4} to capture
//   full          buffer holds an entry
//   entry         buffered {instr, pcPlus4}
// ----------------------------------------------------------------------------
module fetch_skid_buffer
    import fetch_sequencer_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       clear,
    input  logic       load,
    input  logic       drain,
    input  ifidEntry_t loadEntry,
    output logic       full,
    output ifidEntry_t entry
);

    logic       fullQ;
    ifidEntry_t entryQ;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fullQ <= 1'b0;
        end else if (clear) begin
            fullQ <= 1'b0;
        end else if (load) begin
            fullQ <= 1'b1;
        end else if (drain) begin
            fullQ <= 1'b0;
        end
    end

    // NOTE: the payload has no reset; it is never observed while fullQ is 0,
    // so only the valid flag needs one.
    always_ff @(posedge CLK) begin
        if (load) begin
            entryQ <= loadEntry;
        end
    end

    assign full  = fullQ;
    assign entry = entryQ;

endmodule

// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
// Owns the fetch PC and the IF/ID register of the MIPS pipeline and sequences
// instruction-memory requests. Redirects follow delay-slot semantics: the
// instruction after a branch/jump is always fetched, then the target.
// Ports:
//   CLK, RESET_N         clock, asynchronous active-low reset
//   Stall                hazard unit holds IF/ID this cycle
//   Redirect_Valid       taken branch/jump for the IF/ID instruction
//   Redirect_Target      destination (bits [1:0] ignored)
//   Halt                 decode saw a halt
//   IMem_Req/IMem_Addr   registered fetch request and address
//   IMem_Ack/IMem_Data   memory response (may coincide with the request)
//   Fetch_Valid/Fetch_Instr/Fetch_PCPlus4   IF/ID register
//   Halted               sequencer stopped until reset
//   Err_BranchInDelay    sticky: redirect arrived while one was pending
// ----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        Stall,
    input  logic        Redirect_Valid,
    input  logic [31:0] Redirect_Target,
    input  logic        Halt,
    output logic        IMem_Req,
    output logic [31:0] IMem_Addr,
    input  logic        IMem_Ack,
    input  logic [31:0] IMem_Data,
    output logic        Fetch_Valid,
    output logic [31:0] Fetch_Instr,
    output logic [31:0] Fetch_PCPlus4,
    output logic        Halted,
    output logic        Err_BranchInDelay
);

    fetchState_e state;
    logic        imemReqQ;
    logic [31:0] imemAddrQ;
    logic        fetchValidQ;
    ifidEntry_t  ifidQ;
    logic        haltedQ;
    logic        errQ;
    logic        pendValidQ;
    logic [31:0] pendTargetQ;
    logic        haltPendQ;

    logic        accept;
    logic        haltNow;
    logic        halting;
    logic        enterHalt;
    logic        redirNow;
    logic        canLoad;
    logic [31:0] seqAddr;
    logic [31:0] redirTarget;
    ifidEntry_t  acceptEntry;

    logic        skidLoad;
    logic        skidDrain;
    logic        skidFull;
    ifidEntry_t  skidEntry;

    assign accept      = imemReqQ & IMem_Ack;
    assign haltNow     = Halt & ~Stall & (state != HALTED);
    // Once a halt is seen it stays in force until the outstanding request acks.
    assign halting     = haltNow | haltPendQ;
    assign enterHalt   = halting & (~imemReqQ | accept);
    assign redirNow    = Redirect_Valid & ~Stall;
    assign canLoad     = ~Stall | ~fetchValidQ;
    assign seqAddr     = imemAddrQ + INSTR_BYTES;
    assign redirTarget = Redirect_Target & ~32'h0000_0003;
    assign acceptEntry = '{instr: IMem_Data, pcPlus4: seqAddr};

    // NOTE: every signal assigned in this block gets a default first, so no
    // latch can be inferred whichever branch is taken.
    always_comb begin
        skidLoad  = 1'b0;
        skidDrain = 1'b0;
        if (!halting) begin
            skidLoad  = accept & ~canLoad;
            skidDrain = canLoad & skidFull;
        end
    end

    fetch_skid_buffer uSkid (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .clear     (enterHalt),
        .load      (skidLoad),
        .drain     (skidDrain),
        .loadEntry (acceptEntry),
        .full      (skidFull),
        .entry     (skidEntry)
    );

    // NOTE: all state below is assigned with non-blocking <= so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= BOOT;
            imemReqQ    <= 1'b0;
            imemAddrQ   <= RESET_VECTOR;
            fetchValidQ <= 1'b0;
            ifidQ       <= '0;
            haltedQ     <= 1'b0;
            errQ        <= 1'b0;
            pendValidQ  <= 1'b0;
            pendTargetQ <= '0;
            haltPendQ   <= 1'b0;
        end else if (state == HALTED) begin
            imemReqQ <= 1'b0;
        end else if (halting) begin
            // Decode consumed the halting instruction; nothing new is loaded
            // and any data still arriving is discarded.
            fetchValidQ <= 1'b0;
            if (enterHalt) begin
                state     <= HALTED;
                imemReqQ  <= 1'b0;
                haltedQ   <= 1'b1;
                haltPendQ <= 1'b0;
            end else begin
                haltPendQ <= 1'b1;
            end
        end else begin
            // IF/ID: skid entry first, then freshly accepted data.
            if (canLoad) begin
                if (skidFull) begin
                    ifidQ       <= skidEntry;
                    fetchValidQ <= 1'b1;
                end else if (accept) begin
                    ifidQ       <= acceptEntry;
                    fetchValidQ <= 1'b1;
                end else if (!Stall) begin
                    fetchValidQ <= 1'b0;
                end
            end

            // Fetch address. The accept in the redirect cycle is the delay
            // slot; with a full skid the delay slot is already fetched; else
            // the target waits for the next accept.
            if (accept) begin
                if (pendValidQ) begin
                    imemAddrQ  <= pendTargetQ;
                    pendValidQ <= 1'b0;
                end else if (redirNow) begin
                    imemAddrQ <= redirTarget;
                end else begin
                    imemAddrQ <= seqAddr;
                end
            end else if (redirNow && !pendValidQ) begin
                if (skidFull) begin
                    imemAddrQ <= redirTarget;
                end else begin
                    pendValidQ  <= 1'b1;
                    pendTargetQ <= redirTarget;
                end
            end

            if (redirNow && pendValidQ) begin
                errQ <= 1'b1;
            end

            case (state)
                BOOT: begin
                    state    <= FETCH;
                    imemReqQ <= 1'b1;
                end
                FETCH: begin
                    if (accept) begin
                        state    <= Stall ? IDLE : FETCH;
                        imemReqQ <= ~Stall;
                    end
                end
                IDLE: begin
                    if (!Stall && !skidFull) begin
                        state    <= FETCH;
                        imemReqQ <= 1'b1;
                    end
                end
                default: begin
                    imemReqQ <= 1'b0;
                end
            endcase
        end
    end

    assign IMem_Req          = imemReqQ;
    assign IMem_Addr         = imemAddrQ;
    assign Fetch_Valid       = fetchValidQ;
    assign Fetch_Instr       = ifidQ.instr;
    assign Fetch_PCPlus4     = ifidQ.pcPlus4;
    assign Halted            = haltedQ;
    assign Err_BranchInDelay = errQ;

endmodule

// File: tb/tb_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_fetch_sequencer
// Directed bench for fetch_sequencer. Memory returns 0x1000_0000 + word index
// (relative to 0x0040_0000); Ack is either tied to Req or driven by hand.
// ----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        CLK;
    logic        RESET_N;
    logic        Stall;
    logic        Redirect_Valid;
    logic [31:0] Redirect_Target;
    logic        Halt;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ack;
    logic [31:0] IMem_Data;
    logic        Fetch_Valid;
    logic [31:0] Fetch_Instr;
    logic [31:0] Fetch_PCPlus4;
    logic        Halted;
    logic        Err_BranchInDelay;

    logic tieAck;
    logic manualAck;
    int   nCompared;
    int   nMismatched;

    fetch_sequencer dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .Stall             (Stall),
        .Redirect_Valid    (Redirect_Valid),
        .Redirect_Target   (Redirect_Target),
        .Halt              (Halt),
        .IMem_Req          (IMem_Req),
        .IMem_Addr         (IMem_Addr),
        .IMem_Ack          (IMem_Ack),
        .IMem_Data         (IMem_Data),
        .Fetch_Valid       (Fetch_Valid),
        .Fetch_Instr       (Fetch_Instr),
        .Fetch_PCPlus4     (Fetch_PCPlus4),
        .Halted            (Halted),
        .Err_BranchInDelay (Err_BranchInDelay)
    );

    function automatic logic [31:0] wordAt(input logic [31:0] a);
        return 32'h1000_0000 + ((a - 32'h0040_0000) >> 2);
    endfunction

    assign IMem_Data = wordAt(IMem_Addr);
    assign IMem_Ack  = tieAck ? IMem_Req : manualAck;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_req"},   {31'd0, IMem_Req}, 32'd0);
        check({tag, "_addr"},  IMem_Addr, 32'h0040_0000);
        check({tag, "_valid"}, {31'd0, Fetch_Valid}, 32'd0);
        check({tag, "_instr"}, Fetch_Instr, 32'd0);
        check({tag, "_pc4"},   Fetch_PCPlus4, 32'd0);
        check({tag, "_halted"}, {31'd0, Halted}, 32'd0);
        check({tag, "_err"},   {31'd0, Err_BranchInDelay}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int reqHigh;
        nCompared       = 0;
        nMismatched     = 0;
        RESET_N         = 1'b0;
        Stall           = 1'b0;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 32'd0;
        Halt            = 1'b0;
        tieAck          = 1'b1;
        manualAck       = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        checkResetValues("rst0");
        RESET_N = 1'b1;

        // Streaming with Ack tied to Req.
        tick();  // BOOT -> FETCH
        check("boot_req", {31'd0, IMem_Req}, 32'd1);
        check("boot_addr", IMem_Addr, 32'h0040_0000);
        check("boot_valid", {31'd0, Fetch_Valid}, 32'd0);
        tick();
        check("first_valid", {31'd0, Fetch_Valid}, 32'd1);
        check("first_instr", Fetch_Instr, 32'h1000_0000);
        check("first_pc4", Fetch_PCPlus4, 32'h0040_0004);
        check("first_next_addr", IMem_Addr, 32'h0040_0004);
        tick();
        check("second_instr", Fetch_Instr, 32'h1000_0001);
        tick();
        check("jump_pc4", Fetch_PCPlus4, 32'h0040_000C);

        // Jump at 0x0040_0008 to 0x0040_0100, delay slot fetched same cycle.
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h0040_0100;
        tick();
        Redirect_Valid = 1'b0;
        check("dslot_instr", Fetch_Instr, 32'h1000_0003);
        check("dslot_pc4", Fetch_PCPlus4, 32'h0040_0010);
        check("jump_target_addr", IMem_Addr, 32'h0040_0100);
        tick();
        check("target_valid", {31'd0, Fetch_Valid}, 32'd1);
        check("target_instr", Fetch_Instr, 32'h1000_0040);
        check("target_next_addr", IMem_Addr, 32'h0040_0104);

        // Slow memory: redirect to 0x0040_0200 while delay slot is pending.
        tieAck          = 1'b0;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h0040_0200;
        tick();
        Redirect_Valid = 1'b0;
        check("pend_valid_drop", {31'd0, Fetch_Valid}, 32'd0);
        check("pend_addr_hold", IMem_Addr, 32'h0040_0104);
        tick();
        check("pend_req_hold", {31'd0, IMem_Req}, 32'd1);
        manualAck = 1'b1;
        tick();
        manualAck = 1'b0;
        check("pend_dslot_instr", Fetch_Instr, 32'h1000_0041);
        check("pend_dslot_pc4", Fetch_PCPlus4, 32'h0040_0108);
        check("pend_target_addr", IMem_Addr, 32'h0040_0200);
        tieAck = 1'b1;
        tick();
        check("pend_target_instr", Fetch_Instr, 32'h1000_0080);

        // Stall with a request in flight: Ack lands in the skid.
        tieAck = 1'b0;
        Stall  = 1'b1;
        tick();
        check("stall_req_inflight", {31'd0, IMem_Req}, 32'd1);
        manualAck = 1'b1;
        tick();
        manualAck = 1'b0;
        check("skid_req_drop", {31'd0, IMem_Req}, 32'd0);
        check("skid_ifid_hold", Fetch_Instr, 32'h1000_0080);
        tick();
        tick();
        check("stall_req_low", {31'd0, IMem_Req}, 32'd0);
        check("stall_ifid_hold", Fetch_Instr, 32'h1000_0080);
        Stall  = 1'b0;
        tieAck = 1'b1;
        tick();
        check("skid_drain_instr", Fetch_Instr, 32'h1000_0081);
        check("skid_drain_pc4", Fetch_PCPlus4, 32'h0040_0208);
        check("skid_drain_req", {31'd0, IMem_Req}, 32'd0);
        tick();
        check("refetch_req", {31'd0, IMem_Req}, 32'd1);
        check("refetch_addr", IMem_Addr, 32'h0040_0208);
        tick();
        check("refetch_instr", Fetch_Instr, 32'h1000_0082);
        check("refetch_next_addr", IMem_Addr, 32'h0040_020C);

        // Back-to-back redirects while the delay slot is unfetched.
        tieAck          = 1'b0;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h0040_0300;
        tick();
        check("err_clear_first", {31'd0, Err_BranchInDelay}, 32'd0);
        Redirect_Target = 32'h0040_0400;
        tick();
        Redirect_Valid = 1'b0;
        check("err_set", {31'd0, Err_BranchInDelay}, 32'd1);
        check("err_addr_hold", IMem_Addr, 32'h0040_020C);
        manualAck = 1'b1;
        tick();
        manualAck = 1'b0;
        check("err_dslot_instr", Fetch_Instr, 32'h1000_0083);
        check("err_first_target", IMem_Addr, 32'h0040_0300);

        // Halt with a request outstanding.
        Halt = 1'b1;
        tick();
        Halt = 1'b0;
        check("halt_wait_req", {31'd0, IMem_Req}, 32'd1);
        check("halt_wait_halted", {31'd0, Halted}, 32'd0);
        check("halt_wait_valid", {31'd0, Fetch_Valid}, 32'd0);
        manualAck = 1'b1;
        tick();
        manualAck = 1'b0;
        check("halted_set", {31'd0, Halted}, 32'd1);
        check("halted_req", {31'd0, IMem_Req}, 32'd0);
        check("halted_valid", {31'd0, Fetch_Valid}, 32'd0);
        check("halted_discard", Fetch_Instr, 32'h1000_0083);
        tieAck          = 1'b1;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'h0040_0500;
        reqHigh = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (IMem_Req) reqHigh++;
        end
        Redirect_Valid = 1'b0;
        check("halted_quiet_cycles", reqHigh, 32'd0);
        check("halted_sticky", {31'd0, Halted}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        checkResetValues("rst_after_halt");

        // Reset in the middle of a request; a later Ack must be ignored.
        @(posedge CLK);
        #1;
        RESET_N   = 1'b1;
        tieAck    = 1'b0;
        manualAck = 1'b0;
        tick();
        check("mid_req_up", {31'd0, IMem_Req}, 32'd1);
        #3;
        RESET_N = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, IMem_Req}, 32'd0);
        check("mid_rst_addr", IMem_Addr, 32'h0040_0000);
        manualAck = 1'b1;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
        tick();
        check("late_ack_ignored", {31'd0, Fetch_Valid}, 32'd0);
        manualAck = 1'b0;
        tieAck    = 1'b1;

        // Address wrap: redirect to 0xFFFF_FFFF (low bits forced to 00).
        tick();
        check("wrap_pre_instr", Fetch_Instr, 32'h1000_0000);
        Redirect_Valid  = 1'b1;
        Redirect_Target = 32'hFFFF_FFFF;
        tick();
        Redirect_Valid = 1'b0;
        check("wrap_target_addr", IMem_Addr, 32'hFFFF_FFFC);
        check("wrap_dslot_pc4", Fetch_PCPlus4, 32'h0040_0008);
        tick();
        check("wrap_pc4", Fetch_PCPlus4, 32'h0000_0000);
        check("wrap_addr", IMem_Addr, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
